// File: rtl/fpga_template_pkg.sv
// Shared types and constants for the register-bank arbiter.
package fpga_template_pkg;

  // Default register-bank address width.
  localparam int unsigned DefaultAdrBits = 8;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdAddr,
    StRdWait,
    StResp
  } rb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Purely combinational.
// A lone valid requester wins; on contention the one that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       id
);

  // Pick the winner from the valid vector and the previous grant.
  always_comb begin
    gnt = 2'b00;
    id  = 1'b0;
    case (valid)
      2'b01: begin
        gnt = 2'b01;
        id  = 1'b0;
      end
      2'b10: begin
        gnt = 2'b10;
        id  = 1'b1;
      end
      2'b11: begin
        id  = ~last;
        gnt = last ? 2'b01 : 2'b10;
      end
      default: begin
        gnt = 2'b00;
        id  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rb_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register bank.
// One transaction in flight at a time; every bank-side output and every response is
// registered, computed from the next state so it lines up with the state it belongs to.
module rb_arbiter
  import fpga_template_pkg::*;
#(
  parameter int unsigned ADR_BITS = DefaultAdrBits
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                req0_valid,
  input  logic                req0_write,
  input  logic [ADR_BITS-1:0] req0_address,
  input  logic [7:0]          req0_wdata,
  output logic                req0_ready,
  output logic                req0_rvalid,
  output logic [7:0]          req0_rdata,

  input  logic                req1_valid,
  input  logic                req1_write,
  input  logic [ADR_BITS-1:0] req1_address,
  input  logic [7:0]          req1_wdata,
  output logic                req1_ready,
  output logic                req1_rvalid,
  output logic [7:0]          req1_rdata,

  output logic [ADR_BITS-1:0] rb_address,
  output logic [7:0]          rb_data_write_in,
  output logic                rb_reg_en,
  output logic                rb_write_en,
  input  logic [7:0]          rb_data_read_out,

  output logic                busy,
  output logic                grant_id
);

  rb_state_e           state_q, state_d;
  logic                grant_q, grant_d;
  logic [ADR_BITS-1:0] addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          rdata0_q, rdata0_d;
  logic [7:0]          rdata1_q, rdata1_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic                reg_en_q, reg_en_d;
  logic                write_en_q, write_en_d;
  logic                busy_q, busy_d;

  logic [1:0]          arb_gnt;
  logic                arb_id;
  logic                idle_ok;
  logic                accept;
  logic                sel_write;
  logic [ADR_BITS-1:0] sel_addr;
  logic [7:0]          sel_wdata;

  rr_arb2 u_rr_arb2 (
    .valid (({req1_valid, req0_valid})),
    .last  (grant_q),
    .gnt   (arb_gnt),
    .id    (arb_id)
  );

  // Ready is only offered to the winner, only in IDLE, and never while reset is high.
  assign idle_ok    = (state_q == StIdle) && !reset;
  assign req0_ready = idle_ok && arb_gnt[0];
  assign req1_ready = idle_ok && arb_gnt[1];
  assign accept     = idle_ok && (arb_gnt != 2'b00);

  assign sel_write = arb_id ? req1_write   : req0_write;
  assign sel_addr  = arb_id ? req1_address : req0_address;
  assign sel_wdata = arb_id ? req1_wdata   : req0_wdata;

  // Next state, latched request fields and the registered-output next values.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      StIdle: begin
        // Fields are sampled only on an accept.
        if (accept) begin
          grant_d = arb_id;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          state_d = sel_write ? StWr : StRdAddr;
        end
      end
      StWr:     state_d = StIdle;
      StRdAddr: state_d = StRdWait;
      StRdWait: begin
        // Bank data for the address presented last cycle is valid now.
        state_d = StResp;
        if (grant_q) begin
          rdata1_d = rb_data_read_out;
        end else begin
          rdata0_d = rb_data_read_out;
        end
      end
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    reg_en_d   = (state_d == StWr) || (state_d == StRdAddr) || (state_d == StRdWait);
    write_en_d = (state_d == StWr);
    busy_d     = (state_d != StIdle);
    rvalid_d   = 2'b00;
    if (state_d == StResp) begin
      rvalid_d = grant_d ? 2'b10 : 2'b01;
    end
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      grant_q    <= 1'b1;  // requester 0 wins the first contention
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rvalid_q   <= '0;
      reg_en_q   <= 1'b0;
      write_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rvalid_q   <= rvalid_d;
      reg_en_q   <= reg_en_d;
      write_en_q <= write_en_d;
      busy_q     <= busy_d;
    end
  end

  assign rb_address       = addr_q;
  assign rb_data_write_in = wdata_q;
  assign rb_reg_en        = reg_en_q;
  assign rb_write_en      = write_en_q;
  assign req0_rvalid      = rvalid_q[0];
  assign req1_rvalid      = rvalid_q[1];
  assign req0_rdata       = rdata0_q;
  assign req1_rdata       = rdata1_q;
  assign busy             = busy_q;
  assign grant_id         = grant_q;

endmodule

// File: tb/tb_rb_arbiter.sv
// Bench for rb_arbiter: a behavioural register bank, a cycle-level reference model and
// scoreboards for bank writes and read responses.
module tb_rb_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] v = 2'b00;
  logic [1:0] w = 2'b00;
  logic [7:0] a [2];
  logic [7:0] d [2];

  logic       req0_ready, req1_ready, req0_rvalid, req1_rvalid;
  logic [7:0] req0_rdata, req1_rdata;
  logic [7:0] rb_address, rb_data_write_in, bank_rd;
  logic       rb_reg_en, rb_write_en, busy, grant_id;

  always #5 clk = ~clk;

  rb_arbiter #(.ADR_BITS(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .req0_valid       (v[0]),
    .req0_write       (w[0]),
    .req0_address     (a[0]),
    .req0_wdata       (d[0]),
    .req0_ready       (req0_ready),
    .req0_rvalid      (req0_rvalid),
    .req0_rdata       (req0_rdata),
    .req1_valid       (v[1]),
    .req1_write       (w[1]),
    .req1_address     (a[1]),
    .req1_wdata       (d[1]),
    .req1_ready       (req1_ready),
    .req1_rvalid      (req1_rvalid),
    .req1_rdata       (req1_rdata),
    .rb_address       (rb_address),
    .rb_data_write_in (rb_data_write_in),
    .rb_reg_en        (rb_reg_en),
    .rb_write_en      (rb_write_en),
    .rb_data_read_out (bank_rd),
    .busy             (busy),
    .grant_id         (grant_id)
  );

  // Behavioural bank: registered read data, one cycle after the address.
  logic [7:0] bank_mem [256];
  always @(posedge clk) begin
    if (rb_reg_en) begin
      if (rb_write_en) bank_mem[rb_address] <= rb_data_write_in;
      bank_rd <= bank_mem[rb_address];
    end
  end

  typedef struct { logic id; logic [7:0] data; int cyc; } rsp_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; int cyc; } wr_t;

  rsp_t       rsp_q [$];
  wr_t        wr_q [$];
  int         grant_log [$];
  int         acc_cyc_log [$];
  logic [7:0] ref_mem [256];
  logic [7:0] rdata_m [2];
  logic [7:0] addr_m;
  logic       last_m;
  logic [1:0] acc;
  bit         model_ok = 0;
  bit         prev_we = 0;
  int         cyc = 0;
  int         free_cyc = 0;
  int         reg_lo = 1;
  int         reg_hi = 0;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks of the current cycle before the edge, then model update for any accept/reset.
  task automatic eval_cycle();
    int         win;
    logic [1:0] exp_rdy;
    win = -1;
    if (model_ok && cyc >= free_cyc && !reset) begin
      if (v == 2'b11) win = last_m ? 0 : 1;
      else if (v[0]) win = 0;
      else if (v[1]) win = 1;
    end
    exp_rdy = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
    chk("ready", 32'({req1_ready, req0_ready}), 32'(exp_rdy));
    if (model_ok) begin
      chk("busy", 32'(busy), 32'(cyc < free_cyc));
      chk("grant_id", 32'(grant_id), 32'(last_m));
      chk("rb_address", 32'(rb_address), 32'(addr_m));
      chk("rb_reg_en", 32'(rb_reg_en), 32'(cyc >= reg_lo && cyc <= reg_hi));
    end
    if (v[0] && req0_ready) begin grant_log.push_back(0); acc_cyc_log.push_back(cyc); end
    if (v[1] && req1_ready) begin grant_log.push_back(1); acc_cyc_log.push_back(cyc); end
    if (reset) begin
      model_ok   = 1;
      free_cyc   = cyc + 1;
      last_m     = 1'b1;
      addr_m     = 8'h00;
      rdata_m[0] = 8'h00;
      rdata_m[1] = 8'h00;
      if (reg_hi > cyc) reg_hi = cyc;
      rsp_q.delete();
      wr_q.delete();
    end else if (win >= 0) begin
      acc[win] = 1'b1;
      last_m   = logic'(win);
      addr_m   = a[win];
      reg_lo   = cyc + 1;
      if (w[win]) begin
        wr_q.push_back('{addr: a[win], data: d[win], cyc: cyc + 1});
        ref_mem[a[win]] = d[win];
        free_cyc = cyc + 2;
        reg_hi   = cyc + 1;
      end else begin
        rsp_q.push_back('{id: logic'(win), data: ref_mem[a[win]], cyc: cyc + 3});
        free_cyc = cyc + 4;
        reg_hi   = cyc + 2;
      end
    end
  endtask

  // Checks of the registered outputs just after the edge.
  task automatic check_outputs();
    logic [1:0] exp_rv;
    bit         exp_we;
    if (!model_ok) return;
    exp_we = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
    chk("rb_write_en", 32'(rb_write_en), 32'(exp_we));
    if (exp_we) begin
      chk("wr_addr", 32'(rb_address), 32'(wr_q[0].addr));
      chk("wr_data", 32'(rb_data_write_in), 32'(wr_q[0].data));
      void'(wr_q.pop_front());
    end
    chk("we_back_to_back", 32'(prev_we && rb_write_en), 32'(0));
    prev_we = rb_write_en;
    exp_rv = 2'b00;
    if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
      exp_rv = rsp_q[0].id ? 2'b10 : 2'b01;
      rdata_m[rsp_q[0].id] = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    chk("rvalid", 32'({req1_rvalid, req0_rvalid}), 32'(exp_rv));
    chk("req0_rdata", 32'(req0_rdata), 32'(rdata_m[0]));
    chk("req1_rdata", 32'(req1_rdata), 32'(rdata_m[1]));
  endtask

  task automatic tick();
    #1;
    eval_cycle();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    v = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input int n, input logic wr, input logic [7:0] adr, input logic [7:0] dat);
    v[n] = 1'b1;
    w[n] = wr;
    a[n] = adr;
    d[n] = dat;
    acc[n] = 1'b0;
    for (int i = 0; i < 20 && !acc[n]; i++) tick();
    if (!acc[n]) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed no accept expected accept for req%0d", n);
    end
    v[n] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bank_mem[i] = 8'(8'h84 + i);
      ref_mem[i]  = 8'(8'h84 + i);
    end
    bank_rd = 8'h00;
    a[0] = 8'h00; a[1] = 8'h00; d[0] = 8'h00; d[1] = 8'h00;
    acc = 2'b00;
    @(posedge clk);
    #1;

    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_grant_id", 32'(grant_id), 32'(1));
    chk("reset_busy", 32'(busy), 32'(0));

    // Requester 1 reads 0x01 straight after reset.
    send(1, 1'b0, 8'h01, 8'h00);
    idle(5);
    chk("req1_read_0x01", 32'(req1_rdata), 32'(8'h85));
    chk("req0_rdata_untouched", 32'(req0_rdata), 32'(0));

    // Requester 0 writes 0x55 to 0x02 and reads it back.
    do_reset();
    send(0, 1'b1, 8'h02, 8'h55);
    idle(2);
    send(0, 1'b0, 8'h02, 8'h00);
    idle(5);
    chk("readback_0x02", 32'(req0_rdata), 32'(8'h55));

    // Both read in the first cycle after reset: 0 then 1.
    do_reset();
    grant_log.delete();
    w = 2'b00; a[0] = 8'h10; a[1] = 8'h11;
    acc = 2'b00;
    v = 2'b11;
    for (int i = 0; i < 30 && acc != 2'b11; i++) begin
      tick();
      if (acc[0]) v[0] = 1'b0;
      if (acc[1]) v[1] = 1'b0;
    end
    v = 2'b00;
    idle(5);
    chk("both_read_count", 32'(grant_log.size()), 32'(2));
    if (grant_log.size() == 2) begin
      chk("both_read_first", 32'(grant_log[0]), 32'(0));
      chk("both_read_second", 32'(grant_log[1]), 32'(1));
    end

    // Both hold valid writes for 8 transactions: grants alternate.
    grant_log.delete();
    w = 2'b11; a[0] = 8'h20; a[1] = 8'h30; d[0] = 8'hA0; d[1] = 8'hB0;
    v = 2'b11;
    for (int i = 0; i < 60 && grant_log.size() < 8; i++) begin
      acc = 2'b00;
      tick();
      for (int n = 0; n < 2; n++) begin
        if (acc[n]) begin
          a[n] = a[n] + 8'd1;
          d[n] = d[n] + 8'd1;
        end
      end
    end
    v = 2'b00;
    idle(3);
    chk("alt_count", 32'(grant_log.size()), 32'(8));
    for (int i = 0; i < grant_log.size(); i++) chk("alt_grant", 32'(grant_log[i]), 32'(i % 2));

    // Read back two of those writes through the bank.
    send(1, 1'b0, 8'h31, 8'h00);
    send(0, 1'b0, 8'h22, 8'h00);
    idle(5);
    chk("alt_read_req1", 32'(req1_rdata), 32'(8'hB1));
    chk("alt_read_req0", 32'(req0_rdata), 32'(8'hA2));

    // Reset while in RD_WAIT aborts the read; next accept goes to requester 0.
    send(1, 1'b1, 8'h40, 8'h77);
    idle(1);
    send(1, 1'b0, 8'h05, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_rvalid", 32'({req1_rvalid, req0_rvalid}), 32'(0));
    idle(3);
    grant_log.delete();
    w = 2'b11; a[0] = 8'h50; a[1] = 8'h51; d[0] = 8'h01; d[1] = 8'h02;
    acc = 2'b00;
    v = 2'b11;
    for (int i = 0; i < 30 && acc != 2'b11; i++) begin
      tick();
      if (acc[0]) v[0] = 1'b0;
      if (acc[1]) v[1] = 1'b0;
    end
    v = 2'b00;
    idle(2);
    chk("abort_next_count", 32'(grant_log.size()), 32'(2));
    if (grant_log.size() > 0) chk("abort_next_grant", 32'(grant_log[0]), 32'(0));

    // Back-to-back writes from requester 0 accept every 2 cycles.
    acc_cyc_log.delete();
    w[0] = 1'b1; a[0] = 8'h60; d[0] = 8'hC0;
    v[0] = 1'b1;
    for (int i = 0; i < 30 && acc_cyc_log.size() < 4; i++) begin
      acc = 2'b00;
      tick();
      if (acc[0]) begin
        a[0] = a[0] + 8'd1;
        d[0] = d[0] + 8'd1;
      end
    end
    v = 2'b00;
    idle(3);
    chk("b2b_count", 32'(acc_cyc_log.size()), 32'(4));
    for (int i = 1; i < acc_cyc_log.size(); i++)
      chk("b2b_spacing", 32'(acc_cyc_log[i] - acc_cyc_log[i-1]), 32'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
